// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_pkg
// Description : Shared types and helpers for the PLL lock supervisor.
//               - pll_state_e : per-channel supervisor state
//               - cnt_width() : width of a counter that must hold 0..max_val
//               - c_RETRY_W   : width of each channel's RETRY_COUNT field
// Revision    : 1.0 - initial release
// ============================================================================
package pll_sup_pkg;

    // Per-channel supervisor state.
    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_HOLD      = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // Width of each per-channel retry counter (saturates at 15).
    localparam int c_RETRY_W = 4;

    // Bits needed to hold the values 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : pll_sup_pkg
`default_nettype wire

// File: rtl/pll_sup_channel.sv
`default_nettype none
// ============================================================================
// Module      : pll_sup_channel
// Description : Supervisor for a single SB_PLL40. Synchronises the raw LOCK,
//               sequences RESETB, qualifies LOCK over a stability window,
//               retries on lock timeout, relocks after a lock loss and drives
//               the derived-domain reset.
// Ports       : i_clk          reference clock
//               i_rst          synchronous active-high reset
//               i_enable       channel enable (synchronous to i_clk)
//               i_lock         raw PLL LOCK (asynchronous)
//               o_resetb       PLL RESETB (active low)
//               o_bypass       PLL BYPASS
//               o_ready        PLL locked and qualified
//               o_domain_reset active-high reset for the derived domain
//               o_fault        channel is in the failed state
//               o_retry_count  failed lock attempts, saturating at 15
// Revision    : 1.0 - initial release
// ============================================================================
module pll_sup_channel
    import pll_sup_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int BYPASS_ON_FAIL      = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_lock,
    output logic                 o_resetb,
    output logic                 o_bypass,
    output logic                 o_ready,
    output logic                 o_domain_reset,
    output logic                 o_fault,
    output logic [c_RETRY_W-1:0] o_retry_count
);

    localparam int HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
    localparam int STABLE_W  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TIMEOUT_W = cnt_width(LOCK_TIMEOUT_CYCLES);

    // Terminal compare values: a counter at its "last" value on a qualifying
    // cycle means the full duration has just elapsed, so the transition
    // happens on that edge and each counter never exceeds its parameter.
    localparam logic [HOLD_W-1:0]    c_hold_last    = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [STABLE_W-1:0]  c_stable_last  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_retry_max    = c_RETRY_W'(MAX_RETRIES);
    localparam logic [c_RETRY_W-1:0] c_retry_sat    = '1;
    localparam logic                 c_bypass_en    = (BYPASS_ON_FAIL != 0);

    pll_state_e             r_state;
    pll_state_e             w_next;
    logic [1:0]             r_sync;
    logic                   w_lock_s;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [STABLE_W-1:0]    r_stable_cnt;
    logic [TIMEOUT_W-1:0]   r_timeout_cnt;
    logic                   r_low_prev;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_next;
    logic [c_RETRY_W-1:0]   w_retry_inc;
    logic                   w_fail_out;

    // Two-flop synchroniser for the asynchronous LOCK.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_lock};
        end
    end

    assign w_lock_s    = r_sync[1];
    assign w_retry_inc = (r_retry == c_retry_sat) ? c_retry_sat : (r_retry + c_RETRY_W'(1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and retry-count logic.
    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        if (!i_enable) begin
            w_next       = ST_DISABLED;
            w_retry_next = '0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_next = ST_HOLD;
                end
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a coincident timeout.
                    if (w_lock_s && (r_stable_cnt == c_stable_last)) begin
                        w_next       = ST_RUN;
                        w_retry_next = '0;
                    end else if (r_timeout_cnt == c_timeout_last) begin
                        w_retry_next = w_retry_inc;
                        w_next       = (w_retry_inc >= c_retry_max) ? ST_FAIL : ST_HOLD;
                    end
                end
                ST_RUN: begin
                    // Second consecutive low sample is a genuine lock loss.
                    if (!w_lock_s && r_low_prev) begin
                        w_next = ST_HOLD;
                    end
                end
                ST_FAIL: begin
                    w_next = ST_FAIL;
                end
                default: begin
                    w_next = ST_DISABLED;
                end
            endcase
        end
    end

    // Duration counters: each runs only while its state persists and is
    // cleared on every other cycle, so entry into a state always starts at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_cnt    <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_low_prev    <= 1'b0;
            r_retry       <= '0;
        end else begin
            r_retry <= w_retry_next;

            if ((r_state == ST_HOLD) && (w_next == ST_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end

            if ((r_state == ST_WAIT_LOCK) && (w_next == ST_WAIT_LOCK) && w_lock_s) begin
                r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
            end else begin
                r_stable_cnt <= '0;
            end

            if ((r_state == ST_WAIT_LOCK) && (w_next == ST_WAIT_LOCK)) begin
                r_timeout_cnt <= r_timeout_cnt + TIMEOUT_W'(1);
            end else begin
                r_timeout_cnt <= '0;
            end

            r_low_prev <= (r_state == ST_RUN) && (w_next == ST_RUN) && !w_lock_s;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself and have no combinational path from inputs.
    assign w_fail_out = (w_next == ST_FAIL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_resetb       <= 1'b0;
            o_bypass       <= 1'b0;
            o_ready        <= 1'b0;
            o_domain_reset <= 1'b1;
            o_fault        <= 1'b0;
        end else begin
            o_resetb       <= (w_next == ST_WAIT_LOCK) || (w_next == ST_RUN) ||
                              (w_fail_out && c_bypass_en);
            o_bypass       <= w_fail_out && c_bypass_en;
            o_ready        <= (w_next == ST_RUN);
            o_domain_reset <= !((w_next == ST_RUN) || (w_fail_out && c_bypass_en));
            o_fault        <= w_fail_out;
        end
    end

    assign o_retry_count = r_retry;

endmodule : pll_sup_channel
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : Lock supervisor for up to four iCE40 SB_PLL40 instances.
//               One pll_sup_channel per PLL; per-channel outputs are packed
//               into buses and ALL_READY summarises the enabled channels.
// Ports       : REFERENCECLK  reference clock (only clock)
//               RESET         synchronous active-high reset
//               PLL_ENABLE    per-channel enable
//               PLL_LOCK      raw per-PLL LOCK (asynchronous)
//               PLL_RESETB    per-PLL RESETB (active low)
//               PLL_BYPASS    per-PLL BYPASS
//               READY         per-channel locked and qualified
//               DOMAIN_RESET  per-domain active-high reset
//               FAULT         per-channel failed flag
//               RETRY_COUNT   4 bits per channel, channel 0 in the LSBs
//               ALL_READY     registered AND of READY over enabled channels
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_PLL             = 2,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int BYPASS_ON_FAIL      = 0
) (
    input  logic                           REFERENCECLK,
    input  logic                           RESET,
    input  logic [NUM_PLL-1:0]             PLL_ENABLE,
    input  logic [NUM_PLL-1:0]             PLL_LOCK,
    output logic [NUM_PLL-1:0]             PLL_RESETB,
    output logic [NUM_PLL-1:0]             PLL_BYPASS,
    output logic [NUM_PLL-1:0]             READY,
    output logic [NUM_PLL-1:0]             DOMAIN_RESET,
    output logic [NUM_PLL-1:0]             FAULT,
    output logic [c_RETRY_W*NUM_PLL-1:0]   RETRY_COUNT,
    output logic                           ALL_READY
);

    logic r_all_ready;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        pll_sup_channel #(
            .RESET_HOLD_CYCLES   (RESET_HOLD_CYCLES),
            .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
            .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
            .MAX_RETRIES         (MAX_RETRIES),
            .BYPASS_ON_FAIL      (BYPASS_ON_FAIL)
        ) u_chan (
            .i_clk          (REFERENCECLK),
            .i_rst          (RESET),
            .i_enable       (PLL_ENABLE[g]),
            .i_lock         (PLL_LOCK[g]),
            .o_resetb       (PLL_RESETB[g]),
            .o_bypass       (PLL_BYPASS[g]),
            .o_ready        (READY[g]),
            .o_domain_reset (DOMAIN_RESET[g]),
            .o_fault        (FAULT[g]),
            .o_retry_count  (RETRY_COUNT[g*c_RETRY_W +: c_RETRY_W])
        );
    end

    // Disabled channels are treated as ready; with none enabled the summary
    // is forced low so an idle supervisor never reports "all ready".
    always_ff @(posedge REFERENCECLK) begin
        if (RESET) begin
            r_all_ready <= 1'b0;
        end else begin
            r_all_ready <= (|PLL_ENABLE) && (&(READY | ~PLL_ENABLE));
        end
    end

    assign ALL_READY = r_all_ready;

endmodule : pll_supervisor
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_supervisor
// Description : Directed self-checking bench for pll_supervisor. Two DUTs
//               share all stimulus: dut_a leaves the PLL in reset on failure,
//               dut_b bypasses it. Inputs are driven and outputs sampled 1 ns
//               after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic [1:0] lock;

    logic [1:0] resetb_a, bypass_a, ready_a, dr_a, fault_a;
    logic [7:0] retry_a;
    logic       allrdy_a;
    logic [1:0] resetb_b, bypass_b, ready_b, dr_b, fault_b;
    logic [7:0] retry_b;
    logic       allrdy_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pll_supervisor #(
        .NUM_PLL(2), .RESET_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2), .BYPASS_ON_FAIL(0)
    ) dut_a (
        .REFERENCECLK(clk), .RESET(rst), .PLL_ENABLE(en), .PLL_LOCK(lock),
        .PLL_RESETB(resetb_a), .PLL_BYPASS(bypass_a), .READY(ready_a),
        .DOMAIN_RESET(dr_a), .FAULT(fault_a), .RETRY_COUNT(retry_a),
        .ALL_READY(allrdy_a)
    );

    pll_supervisor #(
        .NUM_PLL(2), .RESET_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2), .BYPASS_ON_FAIL(1)
    ) dut_b (
        .REFERENCECLK(clk), .RESET(rst), .PLL_ENABLE(en), .PLL_LOCK(lock),
        .PLL_RESETB(resetb_b), .PLL_BYPASS(bypass_b), .READY(ready_b),
        .DOMAIN_RESET(dr_b), .FAULT(fault_b), .RETRY_COUNT(retry_b),
        .ALL_READY(allrdy_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 2'b00;
        lock = 2'b00;
        tick(3);

        // ---------------- reset state ----------------
        chk("rst_resetb", 32'(resetb_a), 32'h0);
        chk("rst_bypass", 32'(bypass_a), 32'h0);
        chk("rst_ready",  32'(ready_a),  32'h0);
        chk("rst_dr",     32'(dr_a),     32'h3);
        chk("rst_fault",  32'(fault_a),  32'h0);
        chk("rst_retry",  32'(retry_a),  32'h0);
        chk("rst_allrdy", 32'(allrdy_a), 32'h0);

        // RESET outranks enable
        en = 2'b11;
        tick(1);
        chk("rst_over_en_resetb", 32'(resetb_a), 32'h0);
        chk("rst_over_en_dr",     32'(dr_a),     32'h3);

        // ---------------- clean lock ----------------
        rst = 1'b0;
        tick(4);                                   // HOLD edges 1..4
        chk("hold_resetb_low", 32'(resetb_a), 32'h0);
        tick(1);                                   // E0: WAIT_LOCK
        chk("hold_release", 32'(resetb_a), 32'h3);
        tick(10);                                  // E10
        lock = 2'b11;
        tick(9);                                   // E19
        chk("lock_ready_early", 32'(ready_a), 32'h0);
        tick(1);                                   // E20 = 10+2+8
        chk("lock_ready",       32'(ready_a),  32'h3);
        chk("lock_dr",          32'(dr_a),     32'h0);
        chk("lock_allrdy_lag",  32'(allrdy_a), 32'h0);
        tick(1);                                   // E21
        chk("lock_allrdy",      32'(allrdy_a), 32'h1);

        // ---------------- one-cycle glitch ----------------
        lock[0] = 1'b0;
        tick(1);
        lock[0] = 1'b1;
        tick(6);
        chk("glitch_ready", 32'(ready_a), 32'h3);
        chk("glitch_dr",    32'(dr_a),    32'h0);

        // ---------------- 3-cycle loss and relock ----------------
        lock[0] = 1'b0;                            // L0
        tick(3);                                   // L3
        lock[0] = 1'b1;
        chk("loss_ready_hold", 32'(ready_a), 32'h3);
        tick(1);                                   // L4
        chk("loss_ready",  32'(ready_a), 32'h2);
        chk("loss_dr",     32'(dr_a),    32'h1);
        chk("loss_retry",  32'(retry_a), 32'h0);
        tick(1);                                   // L5
        chk("loss_allrdy", 32'(allrdy_a), 32'h0);
        tick(2);                                   // L7
        chk("loss_hold_low", 32'(resetb_a), 32'h2);
        tick(1);                                   // L8
        chk("loss_hold_end", 32'(resetb_a), 32'h3);
        tick(7);                                   // L15
        chk("relock_early", 32'(ready_a), 32'h2);
        tick(1);                                   // L16
        chk("relock_ready", 32'(ready_a), 32'h3);
        chk("relock_retry", 32'(retry_a), 32'h0);

        // ---------------- retry then fail on ch0 ----------------
        lock[0] = 1'b0;                            // L16
        tick(4);                                   // L20
        chk("rf_loss_ready", 32'(ready_a), 32'h2);
        chk("rf_loss_retry", 32'(retry_a), 32'h0);
        tick(3);                                   // L23
        chk("rf_hold1_low", 32'(resetb_a), 32'h2);
        tick(1);                                   // L24
        chk("rf_wait1", 32'(resetb_a), 32'h3);
        tick(31);                                  // L55
        chk("rf_win1_retry", 32'(retry_a),  32'h00);
        chk("rf_win1_resetb", 32'(resetb_a), 32'h3);
        tick(1);                                   // L56
        chk("rf_retry1",  32'(retry_a),  32'h01);
        chk("rf_hold2",   32'(resetb_a), 32'h2);
        tick(3);                                   // L59
        chk("rf_hold2_low", 32'(resetb_a), 32'h2);
        tick(1);                                   // L60
        chk("rf_wait2", 32'(resetb_a), 32'h3);
        tick(31);                                  // L91
        chk("rf_win2_retry", 32'(retry_a), 32'h01);
        chk("rf_win2_fault", 32'(fault_a), 32'h0);
        tick(1);                                   // L92
        chk("rf_retry2",   32'(retry_a),  32'h02);
        chk("rf_fault",    32'(fault_a),  32'h1);
        chk("rf_resetb",   32'(resetb_a), 32'h2);
        chk("rf_dr",       32'(dr_a),     32'h1);
        chk("rf_ready",    32'(ready_a),  32'h2);
        chk("rf_bypass",   32'(bypass_a), 32'h0);
        chk("byp_fault",   32'(fault_b),  32'h1);
        chk("byp_bypass",  32'(bypass_b), 32'h1);
        chk("byp_dr",      32'(dr_b),     32'h0);
        chk("byp_resetb",  32'(resetb_b), 32'h3);
        tick(5);
        chk("rf_sticky",   32'(fault_a),  32'h1);
        chk("rf_allrdy",   32'(allrdy_a), 32'h0);

        // ---------------- disable from FAIL ----------------
        en = 2'b10;
        tick(1);
        chk("dis_fault",  32'(fault_a),  32'h0);
        chk("dis_retry",  32'(retry_a),  32'h0);
        chk("dis_dr",     32'(dr_a),     32'h1);
        chk("dis_allrdy", 32'(allrdy_a), 32'h1);
        chk("dis_bypass", 32'(bypass_b), 32'h0);

        // ---------------- chatter ----------------
        en = 2'b11;
        for (int i = 0; i < 37; i++) begin
            if ((i % 5) == 0) lock[0] = ~lock[0];
            tick(1);
            if (i == 35) begin                     // C36
                chk("chat_ready", 32'(ready_a), 32'h2);
                chk("chat_retry0", 32'(retry_a), 32'h00);
            end
        end                                        // C37
        chk("chat_retry1",  32'(retry_a),  32'h01);
        chk("chat_resetb",  32'(resetb_a), 32'h2);

        // ---------------- disable during WAIT_LOCK ----------------
        lock[0] = 1'b0;
        tick(6);                                   // C43: WAIT_LOCK
        chk("dw_wait",   32'(resetb_a), 32'h3);
        chk("dw_allrdy0", 32'(allrdy_a), 32'h0);
        en = 2'b10;
        tick(1);
        chk("dw_resetb", 32'(resetb_a), 32'h2);
        chk("dw_retry",  32'(retry_a),  32'h00);
        chk("dw_dr",     32'(dr_a),     32'h1);
        chk("dw_allrdy", 32'(allrdy_a), 32'h1);

        // ALL_READY follows ch1 alone
        lock[1] = 1'b0;                            // Q0
        tick(3);
        chk("ch1_ready_hold", 32'(ready_a), 32'h2);
        tick(1);                                   // Q4
        chk("ch1_ready_loss", 32'(ready_a),  32'h0);
        chk("ch1_allrdy_lag", 32'(allrdy_a), 32'h1);
        tick(1);                                   // Q5
        chk("ch1_allrdy",     32'(allrdy_a), 32'h0);

        // ---------------- reset in RUN ----------------
        lock = 2'b11;
        en   = 2'b11;
        tick(30);
        chk("pre_rst_ready",  32'(ready_a),  32'h3);
        chk("pre_rst_allrdy", 32'(allrdy_a), 32'h1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_resetb", 32'(resetb_a), 32'h0);
        chk("mid_rst_ready",  32'(ready_a),  32'h0);
        chk("mid_rst_dr",     32'(dr_a),     32'h3);
        chk("mid_rst_fault",  32'(fault_a),  32'h0);
        chk("mid_rst_retry",  32'(retry_a),  32'h0);
        chk("mid_rst_allrdy", 32'(allrdy_a), 32'h0);
        chk("mid_rst_b_dr",   32'(dr_b),     32'h3);
        rst = 1'b0;
        tick(1);
        chk("post_rst_hold",  32'(resetb_a), 32'h0);
        chk("post_rst_dr",    32'(dr_a),     32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pll_supervisor
`default_nettype wire
